vga_tile_renderer: RTL and testbench

- Parametrised VGA scan-out engine for the game display.
- Generates the VGA timing and fetches a low-resolution background framebuffer, scaled by 2^SCALE_LOG2, from external synchronous memory.
- Overlays a writable tile map of 2^TILE_LOG2-pixel tiles and maps both layers through a writable 16-entry palette.
- Drives the vga driver's red/green/blue inputs, plus syncs and blanking, with a fixed pipeline latency.

---
 rtl/vga_tile_renderer.sv | 206 ++++++++++++++++++++
 tb/tb_vga_tile_renderer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_renderer.sv
// VGA scan-out engine: timing generator, scaled background fetch from external
// synchronous memory, tile-map overlay and 16-entry palette. Three pix_en ticks
// from counter position to output pins.
module vga_tile_renderer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SCALE_LOG2 = 2,
    parameter int TILE_LOG2  = 4,
    parameter int BG_BITS    = 3,
    parameter int TILE_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_en,
    output logic [14:0]          bg_addr,
    input  logic [BG_BITS-1:0]   bg_data,
    input  logic                 map_we,
    input  logic [10:0]          map_waddr,
    input  logic [TILE_BITS-1:0] map_wdata,
    input  logic                 pal_we,
    input  logic [3:0]           pal_waddr,
    input  logic [23:0]          pal_wdata,
    output logic                 map_clearing,
    output logic [7:0]           red,
    output logic [7:0]           green,
    output logic [7:0]           blue,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 blank_n,
    output logic                 frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BG_W    = H_ACTIVE >> SCALE_LOG2;
    localparam int MAP_W   = H_ACTIVE >> TILE_LOG2;
    localparam int MAP_H   = V_ACTIVE >> TILE_LOG2;
    localparam int MAP_N   = MAP_W * MAP_H;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0]   MAP_LAST = 11'(MAP_N - 1);
    localparam logic [10:0]   MAP_NUM  = 11'(MAP_N);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [10:0]            r_clr_idx;
    logic                   w_map_we;
    logic [10:0]            w_map_wa;
    logic [TILE_BITS-1:0]   w_map_wd;
    logic [TILE_BITS-1:0]   r_map [MAP_N];
    logic [23:0]            r_pal [16];

    logic [HW-1:0]          r_h_cnt;
    logic [VW-1:0]          r_v_cnt;
    logic                   w_active, w_hs, w_vs, w_fs;
    logic [14:0]            w_bg_addr;
    logic [10:0]            w_map_raddr;
    logic [3:0]             w_pal_idx;

    logic [TILE_BITS-1:0]   r_tile1, r_tile2;
    logic                   r_act1, r_act2, r_hs1, r_hs2, r_vs1, r_vs2, r_fs1, r_fs2;

    assign w_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs        = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
    assign w_vs        = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
    assign w_fs        = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_bg_addr   = 15'((32'(r_v_cnt) >> SCALE_LOG2) * BG_W + (32'(r_h_cnt) >> SCALE_LOG2));
    assign w_map_raddr = 11'((32'(r_v_cnt) >> TILE_LOG2) * MAP_W + (32'(r_h_cnt) >> TILE_LOG2));
    assign w_pal_idx   = (r_tile2 != '0) ? 4'(8 + 32'(r_tile2)) : 4'(bg_data);
    assign map_clearing = (r_state == S_CLEAR);

    // Clear FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_CLEAR;
        else       r_state <= w_state_nxt;
    end

    // Clear index walks the map once per clk while clearing
    always_ff @(posedge clk) begin
        if (reset)                   r_clr_idx <= '0;
        else if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + 11'd1;
    end

    // Next state and map write-port arbitration (clear owns the port)
    always_comb begin
        w_state_nxt = r_state;
        w_map_we    = 1'b0;
        w_map_wa    = map_waddr;
        w_map_wd    = map_wdata;
        case (r_state)
            S_CLEAR: begin
                w_map_we = 1'b1;
                w_map_wa = r_clr_idx;
                w_map_wd = '0;
                if (r_clr_idx == MAP_LAST) w_state_nxt = S_RUN;
            end
            default: begin
                w_map_we = map_we && (map_waddr < MAP_NUM);
            end
        endcase
    end

    // Tile map write port
    always_ff @(posedge clk) begin
        if (w_map_we) r_map[w_map_wa] <= w_map_wd;
    end

    // Palette with reset contents; lookups in the same clk see the old entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 16; i++)
                r_pal[i] <= (i == 1) ? 24'h0000FA : (i >= 8) ? 24'hFAFA00 : 24'h000000;
        end else if (pal_we) begin
            r_pal[pal_waddr] <= pal_wdata;
        end
    end

    // Horizontal / vertical counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (pix_en) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end
        end
    end

    // Stage 1: background address, map read, timing flags
    always_ff @(posedge clk) begin
        if (reset) begin
            bg_addr <= '0;
            r_tile1 <= '0;
            r_act1  <= 1'b0;
            r_hs1   <= 1'b1;
            r_vs1   <= 1'b1;
            r_fs1   <= 1'b0;
        end else if (pix_en) begin
            if (w_active) bg_addr <= w_bg_addr;
            r_tile1 <= (r_state == S_CLEAR) ? '0 : r_map[w_map_raddr];
            r_act1  <= w_active;
            r_hs1   <= w_hs;
            r_vs1   <= w_vs;
            r_fs1   <= w_fs;
        end
    end

    // Stage 2: align tile code with the returning bg_data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tile2 <= '0;
            r_act2  <= 1'b0;
            r_hs2   <= 1'b1;
            r_vs2   <= 1'b1;
            r_fs2   <= 1'b0;
        end else if (pix_en) begin
            r_tile2 <= r_tile1;
            r_act2  <= r_act1;
            r_hs2   <= r_hs1;
            r_vs2   <= r_vs1;
            r_fs2   <= r_fs1;
        end
    end

    // Stage 3: palette lookup and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            {red, green, blue} <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            blank_n <= 1'b0;
        end else if (pix_en) begin
            {red, green, blue} <= r_act2 ? r_pal[w_pal_idx] : 24'h000000;
            hsync   <= r_hs2;
            vsync   <= r_vs2;
            blank_n <= r_act2;
        end
    end

    // frame_start is qualified by pix_en so it stays one clk wide at any pixel rate
    always_ff @(posedge clk) begin
        if (reset) frame_start <= 1'b0;
        else       frame_start <= pix_en & r_fs2;
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Randomized bench for vga_tile_renderer with a tick-count reference model,
// run on a reduced raster so several frames fit in a short simulation.
module tb_vga_tile_renderer;

    localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACTIVE = 48, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int SCALE_LOG2 = 2, TILE_LOG2 = 3;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam int BG_W    = H_ACTIVE >> SCALE_LOG2;
    localparam int BG_H    = V_ACTIVE >> SCALE_LOG2;
    localparam int MAP_W   = H_ACTIVE >> TILE_LOG2;
    localparam int MAP_H   = V_ACTIVE >> TILE_LOG2;
    localparam int MAP_N   = MAP_W * MAP_H;

    logic        clk = 1'b0, reset = 1'b1, pix_en = 1'b0;
    logic [14:0] bg_addr;
    logic [2:0]  bg_data = '0;
    logic        map_we = 1'b0, pal_we = 1'b0;
    logic [10:0] map_waddr = '0;
    logic [2:0]  map_wdata = '0;
    logic [3:0]  pal_waddr = '0;
    logic [23:0] pal_wdata = '0;
    logic        map_clearing;
    logic [7:0]  red, green, blue;
    logic        hsync, vsync, blank_n, frame_start;

    int n_vec = 0, n_err = 0;

    vga_tile_renderer #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SCALE_LOG2(SCALE_LOG2), .TILE_LOG2(TILE_LOG2), .BG_BITS(3), .TILE_BITS(3)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .bg_addr(bg_addr), .bg_data(bg_data),
        .map_we(map_we), .map_waddr(map_waddr), .map_wdata(map_wdata),
        .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .map_clearing(map_clearing),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // External background memory: one pix_en tick read latency
    logic [2:0] bgmem [BG_W*BG_H];
    always @(posedge clk) if (pix_en) bg_data <= bgmem[bg_addr];

    // Reference model: k counts pix_en ticks since reset; tick k sees the
    // counters at raster position k-1 and presents position k-3 on the pins.
    int unsigned k, m_clr;
    int unsigned tile_q [4];
    logic [2:0]  m_map [MAP_N];
    logic [23:0] m_pal [16];
    logic [23:0] e_rgb;
    logic        e_hs, e_vs, e_bl, e_fs;
    logic [14:0] e_addr;

    always @(posedge clk) begin : model
        int unsigned p, h, v, t, idx;
        if (reset) begin
            k = 0;
            m_clr = 0;
            for (int i = 0; i < 16; i++)
                m_pal[i] = (i == 1) ? 24'h0000FA : (i >= 8) ? 24'hFAFA00 : 24'h000000;
            e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_fs = 1'b0; e_addr = '0;
        end else begin
            e_fs = 1'b0;
            if (pix_en) begin
                k++;
                p = (k - 1) % FRAME; h = p % H_TOTAL; v = p / H_TOTAL;
                if (h < H_ACTIVE && v < V_ACTIVE) begin
                    e_addr = 15'((v >> SCALE_LOG2) * BG_W + (h >> SCALE_LOG2));
                    tile_q[k % 4] = (m_clr < MAP_N) ? 0
                                  : int'(m_map[(v >> TILE_LOG2) * MAP_W + (h >> TILE_LOG2)]);
                end else begin
                    tile_q[k % 4] = 0;
                end
                if (k >= 3) begin
                    p = (k - 3) % FRAME; h = p % H_TOTAL; v = p / H_TOTAL;
                    e_hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
                    e_vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
                    e_bl = (h < H_ACTIVE && v < V_ACTIVE);
                    e_fs = (p == 0);
                    if (e_bl) begin
                        t   = tile_q[(k - 2) % 4];
                        idx = (t != 0) ? 8 + t
                            : int'(bgmem[(v >> SCALE_LOG2) * BG_W + (h >> SCALE_LOG2)]);
                        e_rgb = m_pal[idx];
                    end else begin
                        e_rgb = '0;
                    end
                end
            end
            if (m_clr < MAP_N) begin
                m_map[m_clr] = '0;
                m_clr++;
            end else if (map_we && map_waddr < MAP_N) begin
                m_map[map_waddr] = map_wdata;
            end
            if (pal_we) m_pal[pal_waddr] = pal_wdata;
        end
    end

    // Continuous comparison of every output against the model
    always @(negedge clk) begin
        chk("pixel", 64'({red, green, blue, hsync, vsync, blank_n, frame_start}),
                     64'({e_rgb, e_hs, e_vs, e_bl, e_fs}));
        chk("bg_addr", 64'(bg_addr), 64'(e_addr));
        chk("map_clearing", 64'(map_clearing), 64'(m_clr < MAP_N));
    end

    task automatic rand_writes(input int map_div, input int pal_div);
        map_we    = ($urandom % map_div) == 0;
        map_waddr = 11'($urandom % 64);
        map_wdata = 3'($urandom);
        pal_we    = ($urandom % pal_div) == 0;
        pal_waddr = 4'($urandom);
        pal_wdata = 24'($urandom);
    endtask

    initial begin : main
        int cyc, hs_lo, vs_lo, bl_hi, fs_n;
        for (int i = 0; i < BG_W * BG_H; i++) bgmem[i] = 3'($urandom);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        // Partial clear with external writes attempted, then restart by reset
        repeat (20) begin
            @(negedge clk);
            rand_writes(2, 1000000);
            pal_we = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("clearing_in_reset", 64'(map_clearing), 64'(1));
        reset = 1'b0;
        cyc = 0;
        while (cyc < 4 * MAP_N) begin
            @(negedge clk);
            cyc++;
            map_we = 1'b1;
            map_waddr = 11'($urandom % MAP_N);
            map_wdata = 3'($urandom | 1);
            if (!map_clearing) break;
        end
        chk("clear_len", 64'(cyc), 64'(MAP_N));

        // Centre tile lit with code 1
        @(negedge clk);
        map_we = 1'b1; map_waddr = 11'((MAP_H / 2) * MAP_W + MAP_W / 2); map_wdata = 3'd1;
        @(negedge clk);
        map_we = 1'b0;

        // Two frames at full pixel rate
        hs_lo = 0; vs_lo = 0; bl_hi = 0; fs_n = 0;
        for (int i = 0; i < 2 * FRAME + 3; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                hs_lo += int'(!hsync);
                vs_lo += int'(!vsync);
                bl_hi += int'(blank_n);
                fs_n  += int'(frame_start);
            end
            pix_en = 1'b1;
            rand_writes(32, 256);
            if (i == FRAME + FRAME / 2) begin
                pal_we = 1'b1; pal_waddr = 4'd9; pal_wdata = 24'h00FF00;
            end
        end
        chk("hsync_low_ticks", 64'(hs_lo), 64'(2 * V_TOTAL * H_SYNC));
        chk("vsync_low_ticks", 64'(vs_lo), 64'(2 * V_SYNC * H_TOTAL));
        chk("blank_n_ticks", 64'(bl_hi), 64'(2 * H_ACTIVE * V_ACTIVE));
        chk("frame_starts", 64'(fs_n), 64'(2));

        // Half-rate pixel enable for one frame
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            pix_en = (i % 2) == 0;
            rand_writes(32, 256);
        end

        // Irregular pixel enable
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            pix_en = ($urandom % 3) != 0;
            rand_writes(16, 128);
        end

        @(negedge clk);
        pix_en = 1'b0; map_we = 1'b0; pal_we = 1'b0;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
